// File: rtl/ip_hdr_assembler_pipe_out.sv
// rtl/ip_hdr_assembler_pipe_out.sv - emits one checksummed IPv4 header, then that packet's payload beats
// Payload beats are forwarded without modification. The payload length is checked against the tot_len field of the header.
module ip_hdr_assembler_pipe_out #(
   parameter int DATA_W              = 256,
   parameter int KEEP_W              = DATA_W/8,
   parameter int IP_HDR_W            = 160,
   parameter int TOT_LEN_W           = 16,
   parameter int TS_W                = 64,
   parameter int MAC_INTERFACE_W     = 256,
   parameter int MAC_INTERFACE_BYTES = MAC_INTERFACE_W/8,
   parameter int MAC_PADBYTES_W      = $clog2(MAC_INTERFACE_BYTES),
   parameter int FIFO_W              = MAC_INTERFACE_W + MAC_PADBYTES_W + 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       chksum_out_resp_val,
   input  logic [DATA_W-1:0]          chksum_out_resp_data,
   input  logic [KEEP_W-1:0]          chksum_out_resp_keep,
   input  logic [TS_W-1:0]            chksum_out_resp_user,
   input  logic                       chksum_out_resp_last,
   output logic                       out_chksum_resp_rdy,
   output logic                       out_data_fifo_rd_req,
   input  logic [FIFO_W-1:0]          data_fifo_out_rd_data,
   input  logic                       data_fifo_out_empty,
   output logic                       assembler_dst_hdr_val,
   output logic [IP_HDR_W-1:0]        assembler_dst_ip_hdr,
   output logic [TS_W-1:0]            assembler_dst_timestamp,
   input  logic                       dst_assembler_hdr_rdy,
   output logic                       assembler_dst_data_val,
   output logic [MAC_INTERFACE_W-1:0] assembler_dst_data,
   output logic                       assembler_dst_data_last,
   output logic [MAC_PADBYTES_W-1:0]  assembler_dst_data_padbytes,
   input  logic                       dst_assembler_data_rdy,
   output logic                       assembler_len_err,
   output logic                       assembler_resp_last_err
);

   localparam int CNT_W        = TOT_LEN_W + 1;
   localparam int IP_HDR_BYTES = IP_HDR_W/8;

   typedef enum logic [1:0] {HDR_WAIT, HDR_OUT, DATA_OUT} state_t;

   state_t                r_state;
   logic [IP_HDR_W-1:0]   r_hdr;
   logic [TS_W-1:0]       r_ts;
   logic [CNT_W-1:0]      r_byte_cnt;
   logic                  r_len_err;
   logic                  r_last_err;

   logic                       w_in_wait;
   logic                       w_in_hdr;
   logic                       w_in_data;
   logic                       w_data_hs;
   logic                       w_beat_last;
   logic [MAC_PADBYTES_W-1:0]  w_beat_pad;
   logic [MAC_INTERFACE_W-1:0] w_beat_data;
   logic [CNT_W-1:0]           w_beat_bytes;
   logic [CNT_W:0]             w_cnt_inc;
   logic [CNT_W-1:0]           w_cnt_next;
   logic [CNT_W:0]             w_pkt_sum;
   logic [TOT_LEN_W-1:0]       w_tot_len;
   logic [TOT_LEN_W-1:0]       w_exp_len;
   logic                       w_len_bad;
   logic                       w_unused;

   // The FIFO word is packed as {data, padbytes, last}, with last in bit 0.
   assign w_beat_last = data_fifo_out_rd_data[0];
   assign w_beat_pad  = data_fifo_out_rd_data[MAC_PADBYTES_W:1];
   assign w_beat_data = data_fifo_out_rd_data[FIFO_W-1 -: MAC_INTERFACE_W];

   assign w_in_wait = (r_state == HDR_WAIT);
   assign w_in_hdr  = (r_state == HDR_OUT);
   assign w_in_data = (r_state == DATA_OUT);
   assign w_data_hs = w_in_data & ~data_fifo_out_empty & dst_assembler_data_rdy;

   assign w_cnt_inc  = {1'b0, r_byte_cnt} + (CNT_W+1)'(MAC_INTERFACE_BYTES);
   assign w_cnt_next = w_cnt_inc[CNT_W] ? '1 : w_cnt_inc[CNT_W-1:0];

   // The sum is widened by one bit, so a saturated count can never compare equal by wrapping.
   assign w_beat_bytes = CNT_W'(MAC_INTERFACE_BYTES) - CNT_W'(w_beat_pad);
   assign w_pkt_sum    = {1'b0, r_byte_cnt} + {1'b0, w_beat_bytes};
   assign w_tot_len    = r_hdr[IP_HDR_W-17 -: TOT_LEN_W];
   assign w_exp_len    = w_tot_len - TOT_LEN_W'(IP_HDR_BYTES);
   assign w_len_bad    = (w_pkt_sum != (CNT_W+1)'(w_exp_len));

   assign w_unused = ^{chksum_out_resp_keep, chksum_out_resp_data[DATA_W-IP_HDR_W-1:0]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= HDR_WAIT;
         r_hdr      <= '0;
         r_ts       <= '0;
         r_byte_cnt <= '0;
         r_len_err  <= 1'b0;
         r_last_err <= 1'b0;
      end else begin
         case (r_state)
            HDR_WAIT: begin
               if (chksum_out_resp_val) begin
                  r_hdr      <= chksum_out_resp_data[DATA_W-1 -: IP_HDR_W];
                  r_ts       <= chksum_out_resp_user;
                  r_byte_cnt <= '0;
                  if (!chksum_out_resp_last) r_last_err <= 1'b1;
                  r_state    <= HDR_OUT;
               end
            end
            HDR_OUT: begin
               if (dst_assembler_hdr_rdy) r_state <= DATA_OUT;
            end
            DATA_OUT: begin
               if (w_data_hs) begin
                  if (w_beat_last) begin
                     if (w_len_bad) r_len_err <= 1'b1;
                     r_state <= HDR_WAIT;
                  end else begin
                     r_byte_cnt <= w_cnt_next;
                  end
               end
            end
            default: r_state <= HDR_WAIT;
         endcase
      end
   end

   assign out_chksum_resp_rdy         = w_in_wait;
   assign assembler_dst_hdr_val       = w_in_hdr;
   assign assembler_dst_ip_hdr        = w_in_hdr ? r_hdr : '0;
   assign assembler_dst_timestamp     = w_in_hdr ? r_ts : '0;
   assign assembler_dst_data_val      = w_in_data & ~data_fifo_out_empty;
   assign out_data_fifo_rd_req        = w_data_hs;
   assign assembler_dst_data          = w_in_data ? w_beat_data : '0;
   assign assembler_dst_data_last     = w_in_data & w_beat_last;
   assign assembler_dst_data_padbytes = w_in_data ? w_beat_pad : '0;
   assign assembler_len_err           = r_len_err;
   assign assembler_resp_last_err     = r_last_err;

endmodule

// File: tb/tb_ip_hdr_assembler_pipe_out.sv
// tb/tb_ip_hdr_assembler_pipe_out.sv - directed self-checking bench for ip_hdr_assembler_pipe_out
module tb_ip_hdr_assembler_pipe_out;

   logic         clk = 1'b0;
   logic         rst;
   logic         resp_val;
   logic [255:0] resp_data;
   logic [31:0]  resp_keep;
   logic [63:0]  resp_user;
   logic         resp_last;
   logic         resp_rdy;
   logic         rd_req;
   logic [261:0] rd_data;
   logic         empty;
   logic         hdr_val;
   logic [159:0] ip_hdr;
   logic [63:0]  ts;
   logic         hdr_rdy;
   logic         data_val;
   logic [255:0] data;
   logic         data_last;
   logic [4:0]   data_pad;
   logic         data_rdy;
   logic         len_err;
   logic         last_err;

   logic [261:0] mem [16];
   int           wr_ptr;
   int           rd_ptr;
   logic         force_empty;
   int           n_checks = 0;
   int           n_fail = 0;

   always #5 clk = ~clk;

   ip_hdr_assembler_pipe_out #(.DATA_W(256)) dut (
      .clk                         (clk),
      .rst                         (rst),
      .chksum_out_resp_val         (resp_val),
      .chksum_out_resp_data        (resp_data),
      .chksum_out_resp_keep        (resp_keep),
      .chksum_out_resp_user        (resp_user),
      .chksum_out_resp_last        (resp_last),
      .out_chksum_resp_rdy         (resp_rdy),
      .out_data_fifo_rd_req        (rd_req),
      .data_fifo_out_rd_data       (rd_data),
      .data_fifo_out_empty         (empty),
      .assembler_dst_hdr_val       (hdr_val),
      .assembler_dst_ip_hdr        (ip_hdr),
      .assembler_dst_timestamp     (ts),
      .dst_assembler_hdr_rdy       (hdr_rdy),
      .assembler_dst_data_val      (data_val),
      .assembler_dst_data          (data),
      .assembler_dst_data_last     (data_last),
      .assembler_dst_data_padbytes (data_pad),
      .dst_assembler_data_rdy      (data_rdy),
      .assembler_len_err           (len_err),
      .assembler_resp_last_err     (last_err)
   );

   // First-word-fall-through payload FIFO model
   assign empty   = force_empty | (rd_ptr == wr_ptr);
   assign rd_data = mem[rd_ptr[3:0]];

   always @(posedge clk or posedge rst) begin
      if (rst) rd_ptr <= 0;
      else if (rd_req) rd_ptr <= rd_ptr + 1;
   end

   function automatic logic [261:0] beat(input logic [7:0] id, input logic [4:0] pad, input logic last);
      return {{32{id}}, pad, last};
   endfunction

   function automatic logic [255:0] dat(input logic [7:0] id);
      return {32{id}};
   endfunction

   function automatic logic [159:0] hdr(input logic [15:0] tot_len, input logic [7:0] id);
      return {8'h45, 8'h00, tot_len, {16{id}}};
   endfunction

   task automatic push(input logic [261:0] b);
      mem[wr_ptr[3:0]] = b;
      wr_ptr = wr_ptr + 1;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [259:0] obs, input logic [259:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; resp_val = 0; resp_data = '0; resp_keep = '1; resp_user = '0; resp_last = 1;
      hdr_rdy = 0; data_rdy = 0; force_empty = 0; wr_ptr = 0;
      for (int i = 0; i < 16; i++) mem[i] = '0;
      repeat (2) @(posedge clk);
      #2;
      chk("rst_resp_rdy", resp_rdy, 1);
      chk("rst_hdr_val", hdr_val, 0);
      chk("rst_data_val", data_val, 0);
      chk("rst_rd_req", rd_req, 0);
      chk("rst_ip_hdr", ip_hdr, 0);
      chk("rst_len_err", len_err, 0);
      chk("rst_last_err", last_err, 0);
      cyc();
      rst = 1'b0;

      // Packet 1: 40-byte payload in two beats, length correct
      push(beat(8'h11, 0, 0));
      push(beat(8'h12, 24, 1));
      hdr_rdy = 1; data_rdy = 1;
      resp_val = 1; resp_data = {hdr(60, 8'hA1), {12{8'hA1}}}; resp_user = 64'h1111; #1;
      chk("p1_wait_rdy", resp_rdy, 1);
      chk("p1_wait_no_rd", rd_req, 0);
      cyc(); resp_val = 0; #1;
      chk("p1_hdr_val", hdr_val, 1);
      chk("p1_hdr", ip_hdr, hdr(60, 8'hA1));
      chk("p1_ts", ts, 64'h1111);
      chk("p1_resp_rdy_low", resp_rdy, 0);
      chk("p1_no_data_in_hdr", data_val, 0);
      cyc(); #1;
      chk("p1_b0_val", data_val, 1);
      chk("p1_b0_data", data, dat(8'h11));
      chk("p1_b0_last", data_last, 0);
      chk("p1_b0_rd", rd_req, 1);
      chk("p1_b0_hdr_val", hdr_val, 0);
      cyc(); #1;
      chk("p1_b1_data", data, dat(8'h12));
      chk("p1_b1_last", data_last, 1);
      chk("p1_b1_pad", data_pad, 24);
      cyc(); #1;
      chk("p1_done_val", data_val, 0);
      chk("p1_done_rdy", resp_rdy, 1);
      chk("p1_len_ok", len_err, 0);

      // Packet 2: last beat pad 20 gives 44 bytes against 40 expected
      push(beat(8'h21, 0, 0));
      push(beat(8'h22, 20, 1));
      resp_val = 1; resp_data = {hdr(60, 8'hA2), {12{8'hA2}}}; resp_user = 64'h2222;
      cyc(); resp_val = 0; #1;
      chk("p2_hdr", ip_hdr, hdr(60, 8'hA2));
      cyc(); #1;
      chk("p2_b0_data", data, dat(8'h21));
      cyc(); #1;
      chk("p2_b1_data", data, dat(8'h22));
      chk("p2_b1_pad", data_pad, 20);
      chk("p2_len_before", len_err, 0);
      cyc(); #1;
      chk("p2_len_err", len_err, 1);

      // Packet 3: FIFO empty for 5 data cycles; header arrives with resp_last=0
      force_empty = 1;
      push(beat(8'h31, 0, 1));
      resp_val = 1; resp_last = 0; resp_data = {hdr(52, 8'hA3), {12{8'hA3}}}; resp_user = 64'h3333;
      cyc(); resp_val = 0; resp_last = 1; #1;
      chk("p3_last_err", last_err, 1);
      chk("p3_hdr_val", hdr_val, 1);
      cyc();
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("p3_empty_val", data_val, 0);
         chk("p3_empty_rd", rd_req, 0);
         cyc();
      end
      force_empty = 0; #1;
      chk("p3_b0_val", data_val, 1);
      chk("p3_b0_data", data, dat(8'h31));
      chk("p3_b0_rd", rd_req, 1);
      cyc(); #1;
      chk("p3_done_rdy", resp_rdy, 1);
      chk("p3_len_sticky", len_err, 1);

      // Packet 4: header held 3 cycles, then data rdy toggles 1010
      push(beat(8'h41, 0, 0));
      push(beat(8'h42, 0, 1));
      hdr_rdy = 0; data_rdy = 0;
      resp_val = 1; resp_data = {hdr(84, 8'hA4), {12{8'hA4}}}; resp_user = 64'h4444;
      cyc(); resp_val = 0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("p4_hold_val", hdr_val, 1);
         chk("p4_hold_hdr", ip_hdr, hdr(84, 8'hA4));
         cyc();
      end
      hdr_rdy = 1; #1;
      chk("p4_hdr4_val", hdr_val, 1);
      chk("p4_hdr4", ip_hdr, hdr(84, 8'hA4));
      cyc(); data_rdy = 1; #1;
      chk("p4_t1_data", data, dat(8'h41));
      chk("p4_t1_rd", rd_req, 1);
      cyc(); data_rdy = 0; #1;
      chk("p4_t2_val", data_val, 1);
      chk("p4_t2_data", data, dat(8'h42));
      chk("p4_t2_rd", rd_req, 0);
      cyc(); data_rdy = 1; #1;
      chk("p4_t3_data", data, dat(8'h42));
      chk("p4_t3_rd", rd_req, 1);
      chk("p4_t3_last", data_last, 1);
      cyc(); data_rdy = 0; #1;
      chk("p4_done_val", data_val, 0);
      chk("p4_done_rdy", resp_rdy, 1);

      // Packets A (1 beat) and B (3 beats) back to back, reset during B1
      push(beat(8'h51, 0, 1));
      push(beat(8'h61, 0, 0));
      push(beat(8'h62, 0, 0));
      push(beat(8'h63, 0, 1));
      hdr_rdy = 1; data_rdy = 1;
      resp_val = 1; resp_data = {hdr(52, 8'hA5), {12{8'hA5}}}; resp_user = 64'h5555; #1;
      chk("p5_a_acc_rdy", resp_rdy, 1);
      cyc(); resp_data = {hdr(116, 8'hB5), {12{8'hB5}}}; resp_user = 64'h6666; #1;
      chk("p5_a_hdr", ip_hdr, hdr(52, 8'hA5));
      chk("p5_a_hdr_rdy_low", resp_rdy, 0);
      cyc(); #1;
      chk("p5_a0_data", data, dat(8'h51));
      chk("p5_a0_last", data_last, 1);
      chk("p5_a0_rdy_low", resp_rdy, 0);
      cyc(); #1;
      chk("p5_b_acc_rdy", resp_rdy, 1);
      chk("p5_b_acc_noval", data_val, 0);
      cyc(); resp_val = 0; #1;
      chk("p5_b_hdr", ip_hdr, hdr(116, 8'hB5));
      chk("p5_b_ts", ts, 64'h6666);
      cyc(); #1;
      chk("p5_b0_data", data, dat(8'h61));
      cyc(); #1;
      chk("p5_b1_data", data, dat(8'h62));
      rst = 1; wr_ptr = 0; #1;
      chk("mid_rst_resp_rdy", resp_rdy, 1);
      chk("mid_rst_hdr_val", hdr_val, 0);
      chk("mid_rst_data_val", data_val, 0);
      chk("mid_rst_rd_req", rd_req, 0);
      chk("mid_rst_ip_hdr", ip_hdr, 0);
      chk("mid_rst_len_err", len_err, 0);
      chk("mid_rst_last_err", last_err, 0);
      cyc(); rst = 0;
      cyc(); #1;
      chk("post_rst_resp_rdy", resp_rdy, 1);
      chk("post_rst_hdr_val", hdr_val, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
